// File: rtl/user_io_spi_master.sv
// Host-side SPI master for the user_io command link: one command byte plus 0-4 payload
// bytes per SS_IO frame, MSB first, SPI mode 0. MISO payload bits are returned left-justified.
module user_io_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_code,
    input  logic [2:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_SS_IO,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [5:0]     bit_q, bit_d;
    logic [5:0]     nbits_q, nbits_d;
    logic [2:0]     plen_q, plen_d;
    logic [39:0]    tx_q, tx_d;
    logic [31:0]    rx_q, rx_d;
    logic           sck_q, sck_d;
    logic           ss_q, ss_d;
    logic           mosi_q, mosi_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic [2:0]     len_clamped;

    assign len_clamped = (cmd_len > 3'd4) ? 3'd4 : cmd_len;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        nbits_d     = nbits_q;
        plen_d      = plen_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        sck_d       = sck_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                ss_d  = 1'b1;
                sck_d = 1'b0;
                if (cmd_valid && ready_q) begin
                    state_d = S_SETUP;
                    ss_d    = 1'b0;
                    mosi_d  = cmd_code[7];
                    tx_d    = {cmd_code, cmd_data};
                    plen_d  = len_clamped;
                    nbits_d = {len_clamped, 3'b000} + 6'd8;
                    bit_d   = 6'd0;
                    cnt_d   = '0;
                    rx_d    = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!sck_q) begin
                    // Rising edge: the command byte's MISO bits are not kept.
                    sck_d = 1'b1;
                    cnt_d = '0;
                    if (bit_q >= 6'd8)
                        rx_d = {rx_q[30:0], SPI_MISO};
                end else begin
                    sck_d = 1'b0;
                    cnt_d = '0;
                    if (bit_q == nbits_q - 6'd1) begin
                        state_d = S_HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q + 6'd1;
                        mosi_d = tx_q[38];
                        tx_d   = {tx_q[38:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d     = S_GAP;
                    cnt_d       = '0;
                    ss_d        = 1'b1;
                    rsp_valid_d = 1'b1;
                    // Payload arrived in the low bytes; move it to the top, zero-filled.
                    rsp_data_d  = rx_q << (6'd32 - {plen_q, 3'b000});
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ss_d    = 1'b1;
                sck_d   = 1'b0;
                mosi_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            nbits_q     <= '0;
            plen_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            nbits_q     <= nbits_d;
            plen_q      <= plen_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign SPI_SCK   = sck_q;
    assign SPI_SS_IO = ss_q;
    assign SPI_MOSI  = mosi_q;

endmodule

// File: tb/tb_user_io_spi_master.sv
// Directed bench for user_io_spi_master: bus monitor on the falling clock edge plus a
// pattern-driven slave that presents one MISO bit per SCK rise of the current frame.
module tb_user_io_spi_master;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_code = 8'h00;
    logic [2:0]  cmd_len = 3'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        SPI_SCK;
    logic        SPI_SS_IO;
    logic        SPI_MOSI;
    logic        SPI_MISO;

    user_io_spi_master dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .SPI_SCK   (SPI_SCK),
        .SPI_SS_IO (SPI_SS_IO),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_MISO  (SPI_MISO)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors = 0;
    int miscompares = 0;

    // Bus monitor state (written only by the monitor process)
    int          sck_rises_total = 0;
    int          rsp_total = 0;
    int          ready_busy_viol = 0;
    int          cur_low = 0;
    int          last_frame_low = 0;
    int          high_run = 0;
    int          last_gap = 0;
    logic [5:0]  frame_rises = 6'd0;
    logic [63:0] mosi_hist = 64'h0;
    logic        prev_sck = 1'b0;
    logic        prev_ss = 1'b1;

    always @(negedge clk_sys) begin
        if (SPI_SS_IO) begin
            if (!prev_ss) last_frame_low = cur_low;
            high_run = high_run + 1;
        end else begin
            if (prev_ss) begin
                last_gap    = high_run;
                cur_low     = 0;
                frame_rises = 6'd0;
            end
            cur_low  = cur_low + 1;
            high_run = 0;
        end
        if (SPI_SCK && !prev_sck) begin
            sck_rises_total = sck_rises_total + 1;
            frame_rises     = frame_rises + 6'd1;
            mosi_hist       = {mosi_hist[62:0], SPI_MOSI};
        end
        if (rsp_valid) rsp_total = rsp_total + 1;
        if (cmd_ready && busy) ready_busy_viol = ready_busy_viol + 1;
        prev_sck = SPI_SCK;
        prev_ss  = SPI_SS_IO;
    end

    // Slave: bit k of the frame (k = rises so far) is slave_pat[39-k]
    logic [39:0] slave_pat = 40'h0;
    logic [5:0]  slave_idx;
    assign slave_idx = 6'd39 - frame_rises;
    assign SPI_MISO  = (frame_rises <= 6'd39) ? slave_pat[slave_idx] : 1'b0;

    task automatic start_cmd(input logic [7:0] c, input logic [2:0] l, input logic [31:0] d);
        int t;
        t = 0;
        @(negedge clk_sys);
        while (!cmd_ready && t < 1000) begin
            @(negedge clk_sys);
            t++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_wait: cmd_ready=%b want 1", cmd_ready);
        end
        cmd_code  = c;
        cmd_len   = l;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk_sys);
        cmd_valid = 1'b0;
        cmd_code  = 8'hEE;
        cmd_len   = 3'd3;
        cmd_data  = 32'hDEADDEAD;
    endtask

    task automatic wait_done(input int base_rsp);
        int t;
        t = 0;
        while (rsp_total <= base_rsp && t < 5000) begin
            @(negedge clk_sys);
            t++;
        end
        while (!cmd_ready && t < 5000) begin
            @(negedge clk_sys);
            t++;
        end
        vectors++;
        if (t >= 5000) begin
            miscompares++;
            $display("FAIL done_timeout: waited %0d cycles, want completion", t);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] c, input logic [2:0] l,
                             input logic [31:0] d, input logic [39:0] pat, input int exp_rises,
                             input logic [63:0] exp_mosi, input int exp_low,
                             input logic [31:0] exp_rsp);
        int r0, v0;
        logic [63:0] mask;
        slave_pat = pat;
        r0 = sck_rises_total;
        v0 = rsp_total;
        start_cmd(c, l, d);
        vectors++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept: busy=%b ready=%b want busy=1 ready=0", tag, busy, cmd_ready);
        end
        wait_done(v0);
        mask = (64'd1 << exp_rises) - 64'd1;
        vectors++;
        if (sck_rises_total - r0 !== exp_rises) begin
            miscompares++;
            $display("FAIL %s sck_rises: got %0d want %0d", tag, sck_rises_total - r0, exp_rises);
        end
        vectors++;
        if ((mosi_hist & mask) !== exp_mosi) begin
            miscompares++;
            $display("FAIL %s mosi: got %h want %h", tag, mosi_hist & mask, exp_mosi);
        end
        vectors++;
        if (last_frame_low !== exp_low) begin
            miscompares++;
            $display("FAIL %s ss_low: got %0d want %0d", tag, last_frame_low, exp_low);
        end
        vectors++;
        if (rsp_total - v0 !== 1) begin
            miscompares++;
            $display("FAIL %s rsp_pulses: got %0d want 1", tag, rsp_total - v0);
        end
        vectors++;
        if (rsp_data !== exp_rsp) begin
            miscompares++;
            $display("FAIL %s rsp_data: got %h want %h", tag, rsp_data, exp_rsp);
        end
        $display("%s: cmd %h len %0d rises %0d ss_low %0d rsp %h", tag, c, l,
                 sck_rises_total - r0, last_frame_low, rsp_data);
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (SPI_SS_IO !== 1'b1 || SPI_SCK !== 1'b0 || SPI_MOSI !== 1'b0 || cmd_ready !== 1'b0 ||
            busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: ss=%b sck=%b mosi=%b rdy=%b busy=%b rv=%b rd=%h want 1 0 0 0 0 0 0",
                     SPI_SS_IO, SPI_SCK, SPI_MOSI, cmd_ready, busy, rsp_valid, rsp_data);
        end
        @(negedge clk_sys);
        reset = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 0", cmd_ready);
        end
        @(posedge clk_sys);
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_reset: ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
        $display("reset: ready=%b busy=%b ss=%b", cmd_ready, busy, SPI_SS_IO);
    endtask

    task automatic test_basic();
        run_frame("t1_len1", 8'h15, 3'd1, 32'hA5000000, 40'h0, 16, 64'h15A5, 132, 32'h0);
    endtask

    task automatic test_miso_capture();
        run_frame("t2_miso", 8'h14, 3'd1, 32'h00000000, 40'hFF3C000000, 16, 64'h1400, 132,
                  32'h3C000000);
        run_frame("t2_len2", 8'h20, 3'd2, 32'hAABBCCDD, 40'h001234FFFF, 24, 64'h20AABB, 196,
                  32'h12340000);
    endtask

    task automatic test_len0();
        run_frame("t3_len0", 8'h02, 3'd0, 32'hFFFFFFFF, 40'hFFFFFFFFFF, 8, 64'h02, 68, 32'h0);
    endtask

    task automatic test_clamp();
        run_frame("t4_clamp", 8'h1E, 3'd7, 32'h11223344, 40'h00DEADBEEF, 40, 64'h1E11223344, 324,
                  32'hDEADBEEF);
    endtask

    task automatic test_back_to_back();
        int r0, v0, b0, t;
        slave_pat = 40'h0;
        r0 = sck_rises_total;
        v0 = rsp_total;
        b0 = ready_busy_viol;
        t  = 0;
        @(negedge clk_sys);
        cmd_code  = 8'h03;
        cmd_len   = 3'd0;
        cmd_data  = 32'h0;
        cmd_valid = 1'b1;
        while (rsp_total < v0 + 2 && t < 5000) begin
            @(negedge clk_sys);
            t++;
        end
        cmd_valid = 1'b0;
        wait_done(rsp_total - 1);
        vectors++;
        if (rsp_total - v0 !== 2) begin
            miscompares++;
            $display("FAIL b2b_rsp_pulses: got %0d want 2", rsp_total - v0);
        end
        vectors++;
        if (sck_rises_total - r0 !== 16) begin
            miscompares++;
            $display("FAIL b2b_sck_rises: got %0d want 16", sck_rises_total - r0);
        end
        vectors++;
        if (last_gap !== 5) begin
            miscompares++;
            $display("FAIL b2b_ss_gap: got %0d want 5", last_gap);
        end
        vectors++;
        if (ready_busy_viol - b0 !== 0) begin
            miscompares++;
            $display("FAIL b2b_ready_while_busy: got %0d cycles want 0", ready_busy_viol - b0);
        end
        vectors++;
        if (last_frame_low !== 68) begin
            miscompares++;
            $display("FAIL b2b_ss_low: got %0d want 68", last_frame_low);
        end
        $display("b2b: pulses %0d rises %0d gap %0d", rsp_total - v0, sck_rises_total - r0, last_gap);
    endtask

    task automatic test_reset_mid();
        int v0, t;
        slave_pat = 40'h00FF000000;
        v0 = rsp_total;
        t  = 0;
        start_cmd(8'h15, 3'd1, 32'hA5000000);
        while (frame_rises < 6'd10 && t < 2000) begin
            @(negedge clk_sys);
            t++;
        end
        vectors++;
        if (frame_rises < 6'd10 || SPI_SCK !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reach: rises=%0d sck=%b want >=10 and 1", frame_rises, SPI_SCK);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (SPI_SS_IO !== 1'b1 || SPI_SCK !== 1'b0 || SPI_MOSI !== 1'b0 || busy !== 1'b0 ||
            cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: ss=%b sck=%b mosi=%b busy=%b rdy=%b rv=%b rd=%h want 1 0 0 0 0 0 0",
                     SPI_SS_IO, SPI_SCK, SPI_MOSI, busy, cmd_ready, rsp_valid, rsp_data);
        end
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (20) @(negedge clk_sys);
        vectors++;
        if (rsp_total - v0 !== 0) begin
            miscompares++;
            $display("FAIL mid_no_rsp: got %0d pulses want 0", rsp_total - v0);
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_ready_after: got %b want 1", cmd_ready);
        end
        $display("reset_mid: pulses %0d ready %b", rsp_total - v0, cmd_ready);
        run_frame("t6_after", 8'h15, 3'd1, 32'hA5000000, 40'h0, 16, 64'h15A5, 132, 32'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_miso_capture();
        test_len0();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
